// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path constants: byte width, default FIFO depth and the
// bit layout of the UART status byte read by the register block and microcode.
package uart_rx_fifo_pkg;

    localparam int UART_DATA_WIDTH    = 8;
    localparam int UART_RX_FIFO_DEPTH = 4;

    // Status byte bit positions; bits 7:4 always read as zero.
    localparam int UART_STAT_DATA_AVAIL = 0;
    localparam int UART_STAT_FULL       = 1;
    localparam int UART_STAT_FRAME_ERR  = 2;
    localparam int UART_STAT_OVERSHOOT  = 3;

    function automatic logic [7:0] pack_status(
        input logic data_avail,
        input logic fifo_full,
        input logic frame_err,
        input logic overshoot
    );
        logic [7:0] s;
        s                       = 8'h00;
        s[UART_STAT_DATA_AVAIL] = data_avail;
        s[UART_STAT_FULL]       = fifo_full;
        s[UART_STAT_FRAME_ERR]  = frame_err;
        s[UART_STAT_OVERSHOOT]  = overshoot;
        return s;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Signal bundle between uart_receiver / CPU register block and the receive FIFO.
//
// Handshake: rx_strobe_data_ready is a one-cycle valid pulse with no ready; a
// byte that cannot be stored is dropped and reported through the status flags.
// cpu_read_strobe is a one-cycle pop of the byte currently on rd_data_out.
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) ();
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] rx_data_in;
    logic                  rx_strobe_data_ready;
    logic                  rx_frame_error_in;
    logic                  cpu_read_strobe;
    logic                  cmd_clear_overshoot_error;
    logic                  cmd_clear_frame_error;
    logic [DATA_WIDTH-1:0] rd_data_out;
    logic [ADDR_WIDTH:0]   fifo_count;
    logic [7:0]            status_reg_o;

    modport master (
        output rx_data_in,
        output rx_strobe_data_ready,
        output rx_frame_error_in,
        output cpu_read_strobe,
        output cmd_clear_overshoot_error,
        output cmd_clear_frame_error,
        input  rd_data_out,
        input  fifo_count,
        input  status_reg_o
    );

    modport slave (
        input  rx_data_in,
        input  rx_strobe_data_ready,
        input  rx_frame_error_in,
        input  cpu_read_strobe,
        input  cmd_clear_overshoot_error,
        input  cmd_clear_frame_error,
        output rd_data_out,
        output fifo_count,
        output status_reg_o
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO with sticky overrun / frame-error flags and the packed
// UART status byte. Full/empty come from the occupancy counter, not pointers.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = UART_RX_FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_fifo_if.slave bus
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  frame_error;
    logic                  overshoot_error;

    logic fifo_empty;
    logic fifo_full;
    logic push_req;
    logic push;
    logic pop;
    logic frame_set;
    logic overshoot_set;

    always_comb begin
        fifo_empty    = (count == '0);
        fifo_full     = (count == CNT_FULL);
        pop           = bus.cpu_read_strobe && !fifo_empty;
        push_req      = bus.rx_strobe_data_ready && !bus.rx_frame_error_in;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push          = push_req && (!fifo_full || pop);
        overshoot_set = push_req && fifo_full && !pop;
        frame_set     = bus.rx_strobe_data_ready && bus.rx_frame_error_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Storage carries no reset; contents are only read while count > 0.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= bus.rx_data_in;
        end
    end

    // Sticky flags: a new event in the same cycle overrides the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_error     <= 1'b0;
            overshoot_error <= 1'b0;
        end else begin
            if (frame_set) begin
                frame_error <= 1'b1;
            end else if (bus.cmd_clear_frame_error) begin
                frame_error <= 1'b0;
            end
            if (overshoot_set) begin
                overshoot_error <= 1'b1;
            end else if (bus.cmd_clear_overshoot_error) begin
                overshoot_error <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.rd_data_out  = fifo_empty ? '0 : mem[rd_ptr];
        bus.fifo_count   = count;
        bus.status_reg_o = pack_status(!fifo_empty, fifo_full, frame_error, overshoot_error);
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: push/pop ordering, overrun, frame errors,
// flag clear timing and reset behaviour against hand-computed values.
module tb_uart_rx_fifo;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    logic [7:0] exp_q[$];
    logic [7:0] exp_byte;

    uart_rx_fifo_if #(.DATA_WIDTH(8), .DEPTH(4)) bus ();

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.rx_data_in                = 8'h00;
        bus.rx_strobe_data_ready      = 1'b0;
        bus.rx_frame_error_in         = 1'b0;
        bus.cpu_read_strobe           = 1'b0;
        bus.cmd_clear_overshoot_error = 1'b0;
        bus.cmd_clear_frame_error     = 1'b0;
    endtask

    // Inputs are applied 1 time unit after a rising edge and held for one cycle.
    task automatic cycle(input logic strobe, input logic [7:0] data, input logic fe,
                         input logic rd, input logic clr_ov, input logic clr_fe);
        bus.rx_strobe_data_ready      = strobe;
        bus.rx_data_in                = data;
        bus.rx_frame_error_in         = fe;
        bus.cpu_read_strobe           = rd;
        bus.cmd_clear_overshoot_error = clr_ov;
        bus.cmd_clear_frame_error     = clr_fe;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic push_byte(input logic [7:0] data);
        cycle(1'b1, data, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(data);
    endtask

    // Checks the head byte against the scoreboard, then pops it.
    task automatic pop_check(input string tag);
        exp_byte = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        check(tag, bus.rd_data_out, exp_byte);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_rd", bus.rd_data_out, 8'h00);
        check("reset_count", 8'(bus.fifo_count), 8'h00);
        check("reset_status", bus.status_reg_o, 8'h00);

        // single byte
        push_byte(8'hAB);
        check("one_rd", bus.rd_data_out, 8'hAB);
        check("one_count", 8'(bus.fifo_count), 8'h01);
        check("one_status", bus.status_reg_o, 8'h01);
        pop_check("one_pop");
        check("one_after_rd", bus.rd_data_out, 8'h00);
        check("one_after_status", bus.status_reg_o, 8'h00);

        // fill
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        check("full_count", 8'(bus.fifo_count), 8'h04);
        check("full_status", bus.status_reg_o, 8'h03);

        // overrun: byte dropped, contents untouched
        cycle(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovr_status", bus.status_reg_o, 8'h0B);
        check("ovr_count", 8'(bus.fifo_count), 8'h04);
        check("ovr_head", bus.rd_data_out, 8'h11);

        // clear is visible one cycle later
        bus.cmd_clear_overshoot_error = 1'b1;
        #1;
        check("clr_ov_same_cycle", bus.status_reg_o, 8'h0B);
        @(posedge clk);
        #1;
        idle_inputs();
        check("clr_ov_next", bus.status_reg_o, 8'h03);

        pop_check("drain0");
        pop_check("drain1");
        pop_check("drain2");
        pop_check("drain3");
        check("drain_count", 8'(bus.fifo_count), 8'h00);
        check("drain_status", bus.status_reg_o, 8'h00);

        // full + push with same-cycle pop: no overrun
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h55);
        check("pp_full_count", 8'(bus.fifo_count), 8'h04);
        check("pp_full_status", bus.status_reg_o, 8'h03);
        check("pp_full_head", bus.rd_data_out, 8'h22);
        pop_check("pp_drain0");
        pop_check("pp_drain1");
        pop_check("pp_drain2");
        check("pp_last", bus.rd_data_out, 8'h55);
        pop_check("pp_drain3");
        check("pp_empty_count", 8'(bus.fifo_count), 8'h00);

        // push with pop on empty: only the push happens
        cycle(1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'h66);
        check("pp_empty_count1", 8'(bus.fifo_count), 8'h01);
        check("pp_empty_rd", bus.rd_data_out, 8'h66);
        pop_check("pp_empty_pop");

        // frame error: discarded, flag set
        cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        check("fe_count", 8'(bus.fifo_count), 8'h00);
        check("fe_status", bus.status_reg_o, 8'h04);
        check("fe_rd", bus.rd_data_out, 8'h00);
        cycle(1'b1, 8'h78, 1'b1, 1'b0, 1'b0, 1'b1);
        check("fe_set_wins", bus.status_reg_o, 8'h04);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("fe_cleared", bus.status_reg_o, 8'h00);

        // pop on empty
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("empty_pop_status", bus.status_reg_o, 8'h00);
        check("empty_pop_count", 8'(bus.fifo_count), 8'h00);
        check("empty_pop_rd", bus.rd_data_out, 8'h00);

        // reset mid-stream with a strobe in the reset cycle
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        check("pre_rst_count", 8'(bus.fifo_count), 8'h03);
        check("pre_rst_rd", bus.rd_data_out, 8'h01);
        reset = 1'b1;
        cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        exp_q.delete();
        check("rst_count", 8'(bus.fifo_count), 8'h00);
        check("rst_status", bus.status_reg_o, 8'h00);
        check("rst_rd", bus.rd_data_out, 8'h00);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_strobe_lost", 8'(bus.fifo_count), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer between uart_receiver and the CPU-facing UART register block.
- Captures each byte the receiver strobes out into a small synchronous FIFO and presents the head byte to the CPU data read.
- Keeps sticky overrun and frame-error flags, and packs them with FIFO state into the UART status byte.
- Replaces the single-byte holding register, so the CPU can lag by up to DEPTH bytes before an overrun.

Parameters:
- DATA_WIDTH, 8 (arch_defs_pkg::DATA_WIDTH): byte width.
- DEPTH, 4: FIFO entries; must be a power of 2 and at least 2.
- ADDR_WIDTH, $clog2(DEPTH): pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data_in  in  DATA_WIDTH  byte from uart_receiver
- rx_strobe_data_ready  in  1  one-cycle pulse: rx_data_in valid
- rx_frame_error_in  in  1  qualified by rx_strobe_data_ready: byte had a bad stop bit
- cpu_read_strobe  in  1  one-cycle pop of the head byte
- cmd_clear_overshoot_error  in  1  clears overrun flag
- cmd_clear_frame_error  in  1  clears frame-error flag
- rd_data_out  out  DATA_WIDTH  head byte; 0x00 when empty
- fifo_count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
- status_reg_o  out  8  bit0 data_available, bit1 fifo_full, bit2 frame_error, bit3 overshoot_error, bits7:4 = 0

Behaviour:
- Reset (sync, active-high, on posedge clk):
  - wr_ptr, rd_ptr, count and both error flags go to 0.
  - Memory contents are don't-care.
  - After that edge: rd_data_out = 0x00, fifo_count = 0, status_reg_o = 0x00.
  - Reset has priority over every same-cycle input. A strobe arriving during reset is lost.
- Push:
  - Occurs when rx_strobe_data_ready=1, rx_frame_error_in=0, and the FIFO is not full (or is full with a same-cycle pop).
  - Writes mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Frame-error byte:
  - Occurs when rx_strobe_data_ready=1 and rx_frame_error_in=1.
  - The byte is discarded (not stored) and frame_error is set.
  - Count is unchanged.
- Overrun:
  - Occurs when a push is requested while count==DEPTH and no same-cycle pop.
  - The byte is dropped and overshoot_error is set. FIFO contents are untouched; oldest data is kept.
- Pop:
  - cpu_read_strobe=1 with count>0: rd_ptr increments modulo DEPTH.
  - cpu_read_strobe=1 with count==0: ignored, no flag set, no state change.
- Simultaneous push and pop:
  - Both happen and count is unchanged.
  - This holds when full: no overrun.
  - When empty, only the push happens; count goes to 1.
- Flags:
  - Both error flags are sticky until their clear command.
  - A clear in the same cycle as a new set event: set wins and the flag stays 1.
  - Clear is level-sampled per cycle. The flag reads 1 in the cycle the clear is high and 0 from the next cycle.
- Timing:
  - rd_data_out = mem[rd_ptr] when count>0, else 0x00 (combinational from registered state).
  - A byte pushed at edge N is visible on rd_data_out and status bit0 immediately after edge N (latency 1 clk from strobe).
  - After a pop at edge N, the next entry (or 0x00) shows after edge N.
- status_reg_o is combinational from registered state: bit0 = (count!=0), bit1 = (count==DEPTH).
- Pointer wrap is natural modulo. Full/empty are decided by count, not by pointer compare.

Decomposition:
- Add to a shared uart_defs_pkg (or arch_defs_pkg):
  - status bit index localparams UART_STAT_DATA_AVAIL=0, UART_STAT_FULL=1, UART_STAT_FRAME_ERR=2, UART_STAT_OVERSHOOT=3.
  - UART_RX_FIFO_DEPTH default.
- The UART register block and the CPU microcode read these constants.
- No sub-module: storage array, pointers, counter and flags are inline. A generic sync_fifo would only obscure the overrun and frame-error rules.

Test Plan:
- Reset, then strobe 0xAB → rd_data_out=0xAB, fifo_count=1, status=0x01 the cycle after the strobe; pop → rd_data_out=0x00, status=0x00.
- Strobe 0x11, 0x22, 0x33, 0x44 with no pops → count=4, status=0x03; then pop four times → reads 0x11, 0x22, 0x33, 0x44 in order; count=0.
- With the FIFO full, strobe 0xBB → status=0x0B, contents unchanged (pops return 0x11..0x44). Assert cmd_clear_overshoot_error → bit3 is 1 that cycle and 0 the next.
- With the FIFO full, strobe 0x55 with a same-cycle pop → no overrun, count stays 4, head becomes 0x22, last entry 0x55.
- Strobe 0x77 with rx_frame_error_in=1 → not stored, count unchanged, status bit2=1.
  - cmd_clear_frame_error in the same cycle as a second frame-error strobe → bit2 stays 1.
- Pop on empty → no change, no flags. Assert reset mid-stream with count=3 → count=0 and status=0x00 after the edge; a strobe in the reset cycle is not stored.
